// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light sequencer: per-way light codes and
// the controller phase values reported on the phase output.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_e;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'b000,
    PH_GREEN   = 3'b001,
    PH_YELLOW  = 3'b010,
    PH_FLASH   = 3'b011,
    PH_PREEMPT = 3'b100
  } phase_e;

endpackage

// File: rtl/tl_sec_timer.sv
// One-second prescaler plus seconds counter. clear restarts both counters and
// latches the phase duration, so later duration changes do not disturb a phase.
module tl_sec_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SEC_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [SEC_W-1:0] duration,
  output logic             sec_tick,
  output logic             expire
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic [SEC_W-1:0] secs_q;
  logic [SEC_W-1:0] dur_q;

  assign sec_tick = (pre_q == PRE_W'(TICK_DIV - 1));
  // The tick that completes the last second of the latched duration.
  assign expire   = sec_tick && (secs_q == (dur_q - SEC_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      secs_q <= '0;
      dur_q  <= SEC_W'(1);
    end else if (clear) begin
      pre_q  <= '0;
      secs_q <= '0;
      dur_q  <= (duration == '0) ? SEC_W'(1) : duration;
    end else if (sec_tick) begin
      pre_q  <= '0;
      secs_q <= secs_q + SEC_W'(1);
    end else begin
      pre_q  <= pre_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_seq_ctrl.sv
// N-way traffic light sequencer with demand-actuated skipping, emergency
// preemption and flash mode; lights are decoded from registered state.
module traffic_light_seq_ctrl
  import traffic_light_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SEC_W    = 8,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [SEC_W-1:0]      green_secs,
  input  logic [SEC_W-1:0]      yellow_secs,
  input  logic                  demand_mode,
  input  logic [NUM_WAYS-1:0]   demand,
  input  logic                  preempt,
  input  logic [WAY_W-1:0]      preempt_way,
  output logic [2*NUM_WAYS-1:0] lights,
  output logic [WAY_W-1:0]      active_way,
  output logic [2:0]            phase,
  output logic                  sec_tick
);

  phase_e           state_q, state_d;
  logic [WAY_W-1:0] active_q, active_d;
  logic [WAY_W-1:0] next_q, next_d;
  logic             flash_q, flash_d;
  logic             pend_q, pend_d;
  logic             restart;
  logic             clear;
  logic             expire;
  logic [SEC_W-1:0] dur_sel;
  logic [WAY_W-1:0] seq_way, rr_way, cand_way, idx;
  logic             rr_found;

  tl_sec_timer #(
    .TICK_DIV (TICK_DIV),
    .SEC_W    (SEC_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .duration (dur_sel),
    .sec_tick (sec_tick),
    .expire   (expire)
  );

  assign seq_way = (active_q == WAY_W'(NUM_WAYS - 1)) ? '0 : active_q + WAY_W'(1);

  // First demanding way after active_q, wrapping; falls back to active_q.
  always_comb begin
    rr_way   = active_q;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k < NUM_WAYS; k++) begin
      idx = WAY_W'((int'(active_q) + k) % NUM_WAYS);
      if (!rr_found && demand[idx]) begin
        rr_way   = idx;
        rr_found = 1'b1;
      end
    end
  end

  assign cand_way = demand_mode ? rr_way : seq_way;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PH_IDLE;
      active_q <= '0;
      next_q   <= '0;
      flash_q  <= 1'b1;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      next_q   <= next_d;
      flash_q  <= flash_d;
      pend_q   <= pend_d;
    end
  end

  // Priority: enable low, then preempt, then timer expiry.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    next_d   = next_q;
    flash_d  = flash_q;
    pend_d   = pend_q;
    restart  = 1'b0;
    if (!enable) begin
      state_d = PH_FLASH;
      pend_d  = 1'b0;
      if (state_q != PH_FLASH) flash_d = 1'b1;
      else if (sec_tick)       flash_d = ~flash_q;
    end else begin
      case (state_q)
        PH_IDLE: begin
          state_d  = PH_GREEN;
          active_d = '0;
          pend_d   = 1'b0;
        end
        PH_GREEN: begin
          if (preempt) begin
            if (preempt_way == active_q) begin
              state_d = PH_PREEMPT;
            end else begin
              next_d  = preempt_way;
              pend_d  = 1'b1;
              state_d = PH_YELLOW;
            end
          end else if (expire) begin
            if (cand_way == active_q) begin
              restart = 1'b1;
            end else begin
              next_d  = cand_way;
              state_d = PH_YELLOW;
            end
          end
        end
        PH_YELLOW: begin
          if (preempt) begin
            next_d = preempt_way;
            pend_d = 1'b1;
          end
          if (expire) begin
            active_d = preempt ? preempt_way : next_q;
            state_d  = (preempt || pend_q) ? PH_PREEMPT : PH_GREEN;
            pend_d   = 1'b0;
          end
        end
        PH_PREEMPT: begin
          if (!preempt) state_d = PH_GREEN;
        end
        PH_FLASH: begin
          state_d  = PH_IDLE;
          active_d = '0;
          flash_d  = 1'b1;
        end
        default: state_d = PH_IDLE;
      endcase
    end
  end

  assign clear   = (state_d != state_q) || restart;
  assign dur_sel = (state_d == PH_YELLOW) ? yellow_secs : green_secs;

  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      case (state_q)
        PH_IDLE:    lights[2*i +: 2] = LIGHT_YELLOW;
        PH_GREEN,
        PH_PREEMPT: lights[2*i +: 2] = (active_q == WAY_W'(i)) ? LIGHT_GREEN : LIGHT_RED;
        PH_YELLOW:  lights[2*i +: 2] = ((active_q == WAY_W'(i)) || (next_q == WAY_W'(i)))
                                       ? LIGHT_YELLOW : LIGHT_RED;
        PH_FLASH:   lights[2*i +: 2] = flash_q ? LIGHT_YELLOW : LIGHT_RED;
        default:    lights[2*i +: 2] = LIGHT_RED;
      endcase
    end
  end

  assign active_way = active_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_light_seq_ctrl.sv
// Bench for traffic_light_seq_ctrl: a table of timed segments, each with its
// inputs and the expected per-cycle outputs, checked through a scoreboard.
module tb_traffic_light_seq_ctrl;
  import traffic_light_pkg::*;

  localparam int NW = 4;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [7:0]    green_secs, yellow_secs;
  logic          demand_mode;
  logic [NW-1:0] demand;
  logic          preempt;
  logic [1:0]    preempt_way;
  logic [7:0]    lights;
  logic [1:0]    active_way;
  logic [2:0]    phase;
  logic          sec_tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       en;
    logic       dm;
    logic [3:0] dem;
    logic       pre;
    logic [1:0] pw;
    logic [7:0] gs;
    logic [2:0] ph;
    logic [7:0] lt;
    logic [1:0] way;
    int         n;
  } vec_t;

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] lt;
    logic [1:0] way;
    logic       tick;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  traffic_light_seq_ctrl #(.NUM_WAYS(NW), .TICK_DIV(TD), .SEC_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .green_secs  (green_secs),
    .yellow_secs (yellow_secs),
    .demand_mode (demand_mode),
    .demand      (demand),
    .preempt     (preempt),
    .preempt_way (preempt_way),
    .lights      (lights),
    .active_way  (active_way),
    .phase       (phase),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic add(input logic en, input logic dm, input logic [3:0] dem,
                     input logic pre, input logic [1:0] pw, input logic [7:0] gs,
                     input phase_e ph, input logic [7:0] lt, input logic [1:0] way,
                     input int n);
    vec_t v;
    v.en = en; v.dm = dm; v.dem = dem; v.pre = pre; v.pw = pw; v.gs = gs;
    v.ph = ph; v.lt = lt; v.way = way; v.n = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string name);
    exp_t e, got;
    e   = sb.pop_front();
    got = '{ph: phase, lt: lights, way: active_way, tick: sec_tick};
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d lights=%h way=%0d tick=%0b, want phase=%0d lights=%h way=%0d tick=%0b",
               name, got.ph, got.lt, got.way, got.tick, e.ph, e.lt, e.way, e.tick);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; green_secs = 8'd2; yellow_secs = 8'd1;
    demand_mode = 1'b0; demand = '0; preempt = 1'b0; preempt_way = '0;

    //  en dm dem     pre pw gs     phase       lights  way n
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h02, 0, 8);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_YELLOW,  8'h05, 0, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h08, 1, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd5, PH_GREEN,   8'h08, 1, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_YELLOW,  8'h14, 1, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h20, 2, 8);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_YELLOW,  8'h50, 2, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h80, 3, 8);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_YELLOW,  8'h41, 3, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h02, 0, 8);
    add(1, 1, 4'b0100, 0, 0, 8'd2, PH_YELLOW,  8'h11, 0, 4);
    add(1, 1, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h20, 2, 8);
    add(1, 1, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h20, 2, 16);
    add(1, 1, 4'b0001, 0, 0, 8'd2, PH_YELLOW,  8'h11, 2, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h02, 0, 3);
    add(1, 0, 4'b0000, 1, 3, 8'd2, PH_YELLOW,  8'h41, 0, 4);
    add(1, 0, 4'b0000, 1, 3, 8'd2, PH_PREEMPT, 8'h80, 3, 6);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h80, 3, 8);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_YELLOW,  8'h41, 3, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h02, 0, 2);
    add(1, 0, 4'b0000, 1, 0, 8'd2, PH_PREEMPT, 8'h02, 0, 4);
    add(1, 0, 4'b0000, 1, 2, 8'd2, PH_PREEMPT, 8'h02, 0, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_GREEN,   8'h02, 0, 8);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_YELLOW,  8'h05, 0, 2);
    add(0, 0, 4'b0000, 0, 0, 8'd2, PH_FLASH,   8'h55, 0, 4);
    add(0, 0, 4'b0000, 0, 0, 8'd2, PH_FLASH,   8'h00, 0, 4);
    add(0, 0, 4'b0000, 0, 0, 8'd2, PH_FLASH,   8'h55, 0, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd2, PH_IDLE,    8'h55, 0, 1);
    add(1, 0, 4'b0000, 0, 0, 8'd0, PH_GREEN,   8'h02, 0, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd0, PH_YELLOW,  8'h05, 0, 4);
    add(1, 0, 4'b0000, 0, 0, 8'd0, PH_GREEN,   8'h08, 1, 2);

    // Reset state, then the release cycle is the single IDLE cycle.
    step();
    step();
    sb.push_back('{ph: PH_IDLE, lt: 8'h55, way: 2'd0, tick: 1'b0});
    check("reset");
    reset_n = 1'b1;

    for (int s = 0; s < vecs.size(); s++) begin
      enable      = vecs[s].en;
      demand_mode = vecs[s].dm;
      demand      = vecs[s].dem;
      preempt     = vecs[s].pre;
      preempt_way = vecs[s].pw;
      green_secs  = vecs[s].gs;
      for (int c = 0; c < vecs[s].n; c++) begin
        sb.push_back('{ph: vecs[s].ph, lt: vecs[s].lt, way: vecs[s].way,
                       tick: ((c % TD) == TD - 1)});
        step();
        check($sformatf("seg%0d_cyc%0d", s, c));
      end
    end

    // Asynchronous reset mid-GREEN, checked between clock edges.
    green_secs = 8'd2;
    #2 reset_n = 1'b0;
    #1;
    sb.push_back('{ph: PH_IDLE, lt: 8'h55, way: 2'd0, tick: 1'b0});
    check("async_reset");
    #2 reset_n = 1'b1;
    sb.push_back('{ph: PH_GREEN, lt: 8'h02, way: 2'd0, tick: 1'b0});
    step();
    check("post_reset_green");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_seq_ctrl.md
# traffic_light_seq_ctrl

Parametrised N-way traffic light sequencer. It is the next generation of the fixed 4-way controller: approach count is a parameter, the one-second timebase is generated internally, and green/yellow durations are run-time inputs. It adds demand-actuated skipping, emergency preemption and a flash mode, and drives the per-approach light outputs of the intersection top level.

## Interface
- NUM_WAYS, 4, number of approaches, 2..8; WAY_W = $clog2(NUM_WAYS)
- TICK_DIV, 50_000_000, clk cycles per one-second tick, >= 2
- SEC_W, 8, width of duration inputs and seconds counter
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  0 = flash mode
- green_secs  in  SEC_W  green duration in seconds; 0 is treated as 1
- yellow_secs  in  SEC_W  yellow duration in seconds; 0 is treated as 1
- demand_mode  in  1  1 = skip approaches whose demand bit is 0
- demand  in  NUM_WAYS  vehicle presence, bit i = way i
- preempt  in  1  emergency request, level
- preempt_way  in  WAY_W  approach to preempt to
- lights  out  2*NUM_WAYS  way i at [2i+1:2i]; RED=00, YELLOW=01, GREEN=10
- active_way  out  WAY_W  approach currently served
- phase  out  3  IDLE=000, GREEN=001, YELLOW=010, FLASH=011, PREEMPT=100
- sec_tick  out  1  one-cycle pulse per elapsed second

## Operation
- Timer: the prescaler counts 0..TICK_DIV-1 and asserts sec_tick when it reaches TICK_DIV-1, then wraps. Prescaler and seconds counter clear on every phase entry. The duration is latched at entry. The phase expires on the tick that completes the duration.
- IDLE: all lights YELLOW; active_way <= 0; next cycle -> GREEN.
- GREEN: active_way GREEN, others RED. On expiry, compute next_way:
  - demand_mode=0: next_way = (active_way+1) mod NUM_WAYS.
  - demand_mode=1: round-robin search from active_way+1 with wrap, first set demand bit. If no other way has demand, next_way = active_way.
  - If next_way == active_way, stay in GREEN with the timer restarted. Otherwise -> YELLOW.
- YELLOW: active_way and next_way YELLOW, others RED. On expiry, active_way <= next_way and -> GREEN.
- Preempt:
  - In GREEN with preempt=1 and preempt_way == active_way: -> PREEMPT next cycle.
  - In GREEN with preempt=1 and preempt_way != active_way: next_way <= preempt_way, -> YELLOW immediately.
  - In YELLOW with preempt=1: next_way <= preempt_way and the yellow timer continues. On expiry -> PREEMPT.
- PREEMPT: active_way GREEN, others RED. The way is latched on entry; preempt_way changes are ignored. When preempt falls -> GREEN on the same way with a fresh timer.
- FLASH: entered from any state the cycle after enable=0. Lights toggle between all-YELLOW and all-RED on each sec_tick, starting all-YELLOW. When enable=1 -> IDLE.
- Priority: enable low > preempt > timer expiry.
- lights are decoded combinationally from the registered state, active_way, next_way and flash bit.

## Timing
- Reset values: phase 000, lights all YELLOW, active_way 0, sec_tick 0, counters 0, flash bit 1.
- IDLE lasts exactly 1 cycle.
- GREEN/YELLOW occupy exactly secs*TICK_DIV cycles, counted from the first cycle phase shows the new value. The transition is visible on the cycle after the expiring tick.
- sec_tick is asserted in cycles TICK_DIV-1, 2*TICK_DIV-1, ... after phase entry.
- reset_n low mid-phase returns all state to reset values immediately (asynchronous).
- Changing green_secs/yellow_secs mid-phase does not affect the running phase.

## Structure
- Shared package traffic_light_pkg holds the light encodings (RED/YELLOW/GREEN) and the phase encodings, so the top level and the bench use the same values.
- Sub-module tl_sec_timer contains the prescaler and seconds counter. Inputs: clear, duration. Outputs: sec_tick, expire.
- The FSM, round-robin next-way search and light decode stay in traffic_light_seq_ctrl.

## Test plan
All scenarios use NUM_WAYS=4, TICK_DIV=4, green_secs=2, yellow_secs=1.
- Reset release, demand_mode=0: all YELLOW for 1 cycle, then way0 GREEN 8 cycles, way0+way1 YELLOW 4 cycles, way1 GREEN 8 cycles, …, way3 wraps to way0.
- demand_mode=1, demand=4'b0100 during way0 GREEN -> way0+way2 YELLOW, then way2 GREEN (way1 skipped). demand=4'b0000 -> way0 stays GREEN indefinitely, no YELLOW, sec_tick every 4 cycles.
- preempt=1, preempt_way=3 at cycle 3 of way0 GREEN -> next cycle way0+way3 YELLOW for 4 cycles, then PREEMPT way3 GREEN held. preempt=0 -> GREEN way3 for 8 cycles, then YELLOW way3+way0.
- preempt=1, preempt_way=active_way -> PREEMPT next cycle with no YELLOW. preempt_way changed while held -> no effect.
- enable=0 mid-YELLOW -> FLASH next cycle, lights alternate all-YELLOW/all-RED every 4 cycles. enable=1 -> IDLE 1 cycle, then way0 GREEN.
- green_secs=0 -> GREEN lasts 4 cycles. reset_n pulsed low mid-GREEN -> lights all YELLOW and phase 000 without waiting for a clk edge.
